// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_arb_pkg: shared FSM states, sizes and the rotating-priority pick function
package mux4_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef enum logic {IDLE, LOCKED} state_t;

   typedef struct packed {
      logic [SEL_W-1:0] idx;
      logic             any;
   } pick_t;

   // first set bit searching ptr, ptr+1, ... modulo NUM_REQ; scanning from the
   // far end lets the nearest hit overwrite the others
   function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
      pick_t            p;
      logic [SEL_W-1:0] k;
      p = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         k = ptr + SEL_W'(i);
         if (req[k]) begin
            p.idx = k;
            p.any = 1'b1;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: four producer lanes on one side, one valid/ready consumer on the other
interface mux4_rr_arbiter_if #(parameter int DW = 8);
   logic [3:0]      req;
   logic [3:0]      req_last;
   logic [4*DW-1:0] req_data;
   logic [3:0]      req_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic            out_last;
   logic            out_ready;
   logic [1:0]      sel;
   logic            busy;

   modport master (
      output req, req_last, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_last, sel, busy
   );

   modport slave (
      input  req, req_last, req_data, out_ready,
      output req_ready, out_valid, out_data, out_last, sel, busy
   );
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// rr_pick4: combinational rotating priority encoder over four requests
module rr_pick4
   import mux4_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic [SEL_W-1:0]   idx,
   output logic               any
);
   pick_t pick;

   // winner is the first requester at or after ptr
   always_comb begin
      pick = rr_pick(req, ptr);
      idx  = pick.idx;
      any  = pick.any;
   end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin grant of one shared 4:1 mux, locked per packet with a beat cap
module mux4_rr_arbiter
   import mux4_arb_pkg::*;
#(
   parameter int DW        = 8,
   parameter int MAX_BEATS = 16,
   parameter int CNT_W     = 5
) (
   input logic               clk,
   input logic               rst,
   mux4_rr_arbiter_if.slave  bus
);
   state_t           state, state_nx;
   logic [SEL_W-1:0] sel_q, rr_ptr, idx;
   logic [CNT_W-1:0] beat_cnt;
   logic             any, locked, beat;

   rr_pick4 u_pick (.req(bus.req), .ptr(rr_ptr), .idx(idx), .any(any));

   // output mux and handshake decode; next state follows from the same beat
   always_comb begin
      locked        = state == LOCKED;
      bus.out_valid = locked && bus.req[sel_q];
      bus.out_data  = bus.req_data[sel_q*DW +: DW];
      bus.out_last  = locked && (bus.req_last[sel_q] || beat_cnt == CNT_W'(MAX_BEATS - 1));
      bus.req_ready = locked ? (NUM_REQ'(1) << sel_q) & {NUM_REQ{bus.out_ready}} : '0;
      beat          = bus.out_valid && bus.out_ready;
      state_nx      = locked ? ((beat && bus.out_last) ? IDLE : LOCKED) : (any ? LOCKED : IDLE);
   end

   // grant register, beat counter and rotating pointer advanced past the releasing winner
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sel_q    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         state <= state_nx;
         if (!locked && any) begin
            sel_q    <= idx;
            beat_cnt <= '0;
         end
         if (beat) beat_cnt <= beat_cnt + 1'b1;
         if (beat && bus.out_last) rr_ptr <= sel_q + 1'b1;
      end
   end

   assign bus.sel  = sel_q;
   assign bus.busy = locked;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed stimulus with a per-cycle reference model and literal checks
module tb_mux4_rr_arbiter;
   localparam int DW = 8;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   errors  = 0;

   mux4_rr_arbiter_if #(.DW(DW)) bus ();

   mux4_rr_arbiter #(.DW(DW), .MAX_BEATS(MB), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: grant holder, rotating pointer and beats granted so far
   bit       m_ok = 0;
   bit       m_locked;
   int       m_g, m_ptr, m_cnt;
   bit       prev_busy = 0;
   int       glog[$];
   logic [10:0] blog[$];

   always @(negedge clk) begin
      bit       ev, el;
      logic [3:0] er;
      if (m_ok) begin
         ev = m_locked && bus.req[m_g];
         el = m_locked && (bus.req_last[m_g] || m_cnt == MB - 1);
         er = (m_locked && bus.out_ready) ? 4'(1 << m_g) : 4'd0;
         chk("busy", 32'(bus.busy), 32'(m_locked));
         chk("sel", 32'(bus.sel), 32'(m_g));
         chk("out_valid", 32'(bus.out_valid), 32'(ev));
         chk("out_last", 32'(bus.out_last), 32'(el));
         chk("req_ready", 32'(bus.req_ready), 32'(er));
         if (ev) chk("out_data", 32'(bus.out_data), 32'(bus.req_data[m_g*DW +: DW]));
      end
      if (bus.busy && !prev_busy) glog.push_back(int'(bus.sel));
      prev_busy = bus.busy;
      if (!rst && bus.out_valid && bus.out_ready) blog.push_back({bus.sel, bus.out_last, bus.out_data});
      if (rst) begin
         m_locked = 0; m_g = 0; m_ptr = 0; m_cnt = 0; m_ok = 1;
      end else if (!m_locked) begin
         for (int j = 3; j >= 0; j--)
            if (bus.req[(m_ptr + j) % 4]) begin
               m_g = (m_ptr + j) % 4;
               m_locked = 1;
               m_cnt = 0;
            end
      end else if (bus.req[m_g] && bus.out_ready) begin
         if (bus.req_last[m_g] || m_cnt == MB - 1) begin
            m_locked = 0;
            m_ptr = (m_g + 1) % 4;
         end
         m_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [7:0] v);
      bus.req_data[i*DW +: DW] = v;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req = '0;
      bus.req_last = '0;
      tick();
      rst = 1'b0;
      glog.delete();
      blog.delete();
   endtask

   initial begin
      bus.req = 4'b1001;
      bus.req_last = 4'b0000;
      bus.req_data = 32'h3A_2A_1A_0A;
      bus.out_ready = 1'b1;
      // reset held three cycles with requests pending
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_busy", 32'(bus.busy), 0);
         chk("rst_sel", 32'(bus.sel), 0);
         chk("rst_ready", 32'(bus.req_ready), 0);
      end
      rst = 1'b0;
      tick();
      chk("post_rst_sel", 32'(bus.sel), 0);
      chk("post_rst_busy", 32'(bus.busy), 1);

      // single three-beat packet on lane 2
      do_reset();
      bus.req = 4'b0100;
      bus.out_ready = 1'b1;
      set_lane(2, 8'hA1);
      tick();
      for (int b = 0; b < 3; b++) begin
         set_lane(2, 8'(8'hA1 + b));
         bus.req_last = (b == 2) ? 4'b0100 : 4'b0000;
         #1;
         chk("pkt_data", 32'(bus.out_data), 32'(8'hA1 + b));
         chk("pkt_last", 32'(bus.out_last), 32'(b == 2));
         tick();
      end
      chk("pkt_bubble", 32'(bus.busy), 0);
      bus.req = 4'b1001;
      bus.req_last = 4'b0000;
      tick();
      chk("pkt_ptr3", 32'(bus.sel), 3);

      // all four requesting one-beat packets
      do_reset();
      bus.req = 4'b1111;
      bus.req_last = 4'b1111;
      for (int c = 0; c < 16; c++) tick();
      chk("rr_count", 32'(glog.size()), 8);
      for (int k = 0; k < glog.size() && k < 8; k++) chk("rr_order", 32'(glog[k]), 32'(k % 4));

      // backpressure on requester 1
      do_reset();
      bus.req = 4'b0010;
      bus.req_last = 4'b0000;
      bus.out_ready = 1'b0;
      set_lane(1, 8'h51);
      tick();
      begin
         logic [3:0] pat;
         logic [7:0] d;
         pat = 4'b1001;
         d = 8'h51;
         for (int k = 3; k >= 0; k--) begin
            bus.out_ready = pat[k];
            #1;
            chk("bp_ready", 32'(bus.req_ready), pat[k] ? 32'h2 : 32'h0);
            chk("bp_data", 32'(bus.out_data), 32'(d));
            tick();
            if (pat[k]) begin
               d = d + 8'h1;
               set_lane(1, d);
            end
         end
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_last3", 32'(bus.out_last), 0);
      tick();
      chk("bp_last4", 32'(bus.out_last), 1);
      tick();
      chk("bp_release", 32'(bus.busy), 0);

      // fairness cap with last never asserted
      do_reset();
      bus.req = 4'b1001;
      bus.req_last = 4'b0000;
      bus.out_ready = 1'b1;
      set_lane(0, 8'h0A);
      set_lane(3, 8'h3A);
      for (int c = 0; c < 11; c++) tick();
      chk("cap_sel", 32'(bus.sel), 0);
      chk("cap_busy", 32'(bus.busy), 1);
      chk("cap_beats", 32'(blog.size()), 8);
      for (int k = 0; k < blog.size() && k < 8; k++)
         chk("cap_beat", 32'(blog[k]), (k < 4) ? 32'({2'd0, k == 3, 8'h0A}) : 32'({2'd3, k == 7, 8'h3A}));
      chk("cap_grants", 32'(glog.size()), 2);
      if (glog.size() == 2) chk("cap_g2", 32'(glog[1]), 3);

      // reset in the middle of a packet
      do_reset();
      bus.req = 4'b0100;
      bus.req_last = 4'b0100;
      tick();
      tick();
      bus.req = 4'b0010;
      bus.req_last = 4'b0000;
      tick();
      chk("mid_sel1", 32'(bus.sel), 1);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("mid_busy", 32'(bus.busy), 0);
      chk("mid_valid", 32'(bus.out_valid), 0);
      rst = 1'b0;
      bus.req = 4'b1111;
      tick();
      chk("mid_restart", 32'(bus.sel), 0);
      chk("mid_rebusy", 32'(bus.busy), 1);

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 4:1 datapath mux between four requesters. It picks a winner, drives the 2-bit mux select and locks the grant for a whole packet. The packet ends on a last-flagged beat or after a fairness cap of MAX_BEATS. It sits between four producer ports and a single valid/ready consumer.

Parameters:
DW, 8, data width per requester lane
MAX_BEATS, 16, maximum beats per grant before forced release (>=1)
CNT_W, 5, beat counter width; must satisfy 2^CNT_W > MAX_BEATS

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  4  per-requester valid, one bit per requester
req_last  input  4  per-requester last-beat flag, qualified by req
req_data  input  4*DW  lane i occupies bits [i*DW +: DW]
req_ready  output  4  per-requester accept, at most one bit high
out_valid  output  1  output beat valid
out_data  output  DW  muxed data, equal to req_data lane sel
out_last  output  1  beat closes the grant (req_last or cap reached)
out_ready  input  1  consumer accept
sel  output  2  registered mux select, equal to the current grant index
busy  output  1  high while a grant is locked

Behaviour:
- Beat transfer: a beat transfers when out_valid && out_ready.
- FSM states: IDLE, LOCKED.
- Reset values: state=IDLE, sel=0, rr_ptr=0, beat_cnt=0, busy=0, out_valid=0, req_ready=0, out_last=0.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set req bit searching rr_ptr, rr_ptr+1, ... modulo 4.
  - Register the winner into sel, go to LOCKED, clear beat_cnt.
  - Grant latency is 1 cycle from req to busy, so no beat moves in the arbitration cycle.
- LOCKED, combinational outputs:
  - out_valid = req[sel]
  - out_data = lane sel
  - req_ready = onehot(sel) & {4{out_ready}}
  - out_last = req_last[sel] || (beat_cnt == MAX_BEATS-1)
- LOCKED, per beat: beat_cnt increments on each beat.
- LOCKED, release: a beat with out_last set returns the FSM to IDLE and sets rr_ptr = sel+1 (wraps 3->0).
  - The next arbitration happens in the following cycle, so there is one idle bubble between grants.
- Requester drop: if req[sel] drops mid-packet, the grant stays locked; out_valid=0, no beats, no timeout.
- Other requesters: requests from non-granted requesters never affect sel while LOCKED.
- Outside LOCKED: out_valid=0, req_ready=0, out_last=0, and out_data is don't-care (drive lane sel).
- Simultaneous requests: in IDLE, pure rotating priority from rr_ptr; no requester is ever starved.
  - Each requester wins at least once in every 4 grants while it keeps requesting.
- Beat cap: after MAX_BEATS beats the grant is force-released even if req_last was never asserted.
  - The same requester may win again only after the other active requesters have been served.
- MAX_BEATS=1: every beat has out_last=1.
- Reset mid-packet: reset takes effect at the next edge, returns to the IDLE reset values and discards the in-flight packet state.

Decomposition:
- Shared package mux4_arb_pkg holds:
  - state typedef enum {IDLE, LOCKED}
  - NUM_REQ=4 and SEL_W=2 constants
  - function rr_pick(req, ptr) returning index and found flag
- One sub-module is natural: rr_pick4, a combinational rotating priority encoder.
  - Its inputs are req[3:0] and ptr[1:0]; its outputs are idx[1:0] and any.
  - The top-level module holds the FSM, beat counter and output mux.

Test Plan:
- Reset with req=4'b1001 and rst held 3 cycles -> busy=0, sel=0, req_ready=0 throughout reset. One cycle after release: sel=0, busy=1.
- Single packet: req[2]=1, lane2 data 8'hA1,A2,A3 with last on the 3rd beat, out_ready=1 -> out_data A1,A2,A3 on consecutive cycles, out_last only on A3, then one IDLE cycle, rr_ptr=3.
- Round-robin: req=4'b1111 continuously, 1-beat packets (last=1) -> grant order 0,1,2,3,0,... on sel, one bubble cycle between grants.
- Backpressure: requester 1 granted, out_ready toggles 1,0,0,1 -> req_ready[1] mirrors out_ready, data holds stable while stalled, beat_cnt advances only on transfer cycles.
- Fairness cap: MAX_BEATS=4, req[0] and req[3] both stream with last never set -> requester 0 gets 4 beats (4th beat out_last=1), then requester 3 gets 4 beats, then requester 0 again.
- Reset mid-packet: rst pulse after 2 of 5 beats of requester 1 -> next cycle busy=0 and out_valid=0. After rst deasserts, arbitration restarts from rr_ptr=0.
